// File: rtl/cache_wb_serializer.sv
// D-cache write-back serializer.
// Takes one evicted dirty line in a single handshake and streams it to memory
// as one burst: a request (line-aligned address, fixed length) followed by
// LINE_WORDS data beats, lowest-offset word first. Mirrors the refill path,
// which shifts words into the top of a line; here words leave from the bottom.
// Every output comes from a register, so there is no input-to-output path.

module cache_wb_serializer #(
  parameter int DATA_WIDTH   = 32,
  parameter int LINE_WORDS   = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,

  // Controller side (EVICT state)
  input  logic                             wb_valid,
  output logic                             wb_ready,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH*LINE_WORDS-1:0] wb_line,
  output logic                             wb_done,

  // Memory write request channel
  output logic                             mem_wr_req_valid,
  input  logic                             mem_wr_req_ready,
  output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
  output logic [7:0]                       mem_wr_len,

  // Memory write data channel
  output logic                             mem_wr_data_valid,
  input  logic                             mem_wr_data_ready,
  output logic [DATA_WIDTH-1:0]            mem_wr_data,
  output logic                             mem_wr_data_last
);

  localparam int LINE_W = DATA_WIDTH * LINE_WORDS;
  localparam int CNT_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [LINE_W-1:0]       line_sr;
  logic [ADDR_WIDTH-1:0]   addr_r;

  // The byte offset inside the line is dropped; the burst always starts at
  // the line base.
  logic                    unused_offset_bits;
  assign unused_offset_bits = ^wb_addr[OFFSET_WIDTH-1:0];

  // Address and current beat are taken straight from the holding registers,
  // so they stay stable for as long as memory stalls.
  assign mem_wr_addr = addr_r;
  assign mem_wr_data = line_sr[DATA_WIDTH-1:0];
  assign mem_wr_len  = 8'(LINE_WORDS - 1);

  // Burst sequencer: state, beat counter, line shift register and all
  // handshake outputs advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      beat_cnt          <= '0;
      line_sr           <= '0;
      addr_r            <= '0;
      wb_ready          <= 1'b1;
      wb_done           <= 1'b0;
      mem_wr_req_valid  <= 1'b0;
      mem_wr_data_valid <= 1'b0;
      mem_wr_data_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wb_done <= 1'b0;
          // wb_ready is high throughout IDLE, so wb_valid alone completes
          // the handshake. The line and address are sampled only here.
          if (wb_valid) begin
            line_sr          <= wb_line;
            addr_r           <= {wb_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            beat_cnt         <= '0;
            wb_ready         <= 1'b0;
            mem_wr_req_valid <= 1'b1;
            state            <= REQ;
          end
        end

        REQ: begin
          // Data ready is ignored here; the data channel only opens once the
          // request has been taken.
          if (mem_wr_req_ready) begin
            mem_wr_req_valid  <= 1'b0;
            mem_wr_data_valid <= 1'b1;
            mem_wr_data_last  <= (LAST_IDX == '0);
            state             <= DATA;
          end
        end

        DATA: begin
          if (mem_wr_data_ready) begin
            line_sr <= line_sr >> DATA_WIDTH;
            if (beat_cnt == LAST_IDX) begin
              // Counter parks at the last index; it is cleared on next accept.
              mem_wr_data_valid <= 1'b0;
              mem_wr_data_last  <= 1'b0;
              wb_done           <= 1'b1;
              state             <= DONE;
            end else begin
              beat_cnt         <= beat_cnt + CNT_W'(1);
              mem_wr_data_last <= ((beat_cnt + CNT_W'(1)) == LAST_IDX);
            end
          end
        end

        DONE: begin
          // One-cycle completion pulse; a new line is accepted from the
          // following cycle on.
          wb_done  <= 1'b0;
          wb_ready <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          wb_ready          <= 1'b1;
          wb_done           <= 1'b0;
          mem_wr_req_valid  <= 1'b0;
          mem_wr_data_valid <= 1'b0;
          mem_wr_data_last  <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_wb_serializer.sv
// Self-checking bench for cache_wb_serializer. Expected beats are pushed into
// a scoreboard queue when a line is offered and popped as beats are accepted.

module tb_cache_wb_serializer;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int AW = 32;
  localparam int OW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic              wb_ready;
  logic [AW-1:0]     wb_addr;
  logic [DW*LW-1:0]  wb_line;
  logic              wb_done;
  logic              mem_wr_req_valid;
  logic              mem_wr_req_ready;
  logic [AW-1:0]     mem_wr_addr;
  logic [7:0]        mem_wr_len;
  logic              mem_wr_data_valid;
  logic              mem_wr_data_ready;
  logic [DW-1:0]     mem_wr_data;
  logic              mem_wr_data_last;

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  cache_wb_serializer #(
    .DATA_WIDTH(DW), .LINE_WORDS(LW), .ADDR_WIDTH(AW), .OFFSET_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_line(wb_line), .wb_done(wb_done),
    .mem_wr_req_valid(mem_wr_req_valid), .mem_wr_req_ready(mem_wr_req_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_len(mem_wr_len),
    .mem_wr_data_valid(mem_wr_data_valid), .mem_wr_data_ready(mem_wr_data_ready),
    .mem_wr_data(mem_wr_data), .mem_wr_data_last(mem_wr_data_last)
  );

  function automatic logic [DW*LW-1:0] make_line(input logic [DW-1:0] base);
    logic [DW*LW-1:0] l;
    l = '0;
    for (int i = 0; i < LW; i++) l[DW*i +: DW] = base + DW'(i);
    return l;
  endfunction

  task automatic push_line(input logic [DW*LW-1:0] l);
    for (int i = 0; i < LW; i++) exp_q.push_back(l[DW*i +: DW]);
  endtask

  // Advance one clock and land 1 time unit after the edge (sample point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_valid = 1'b0; wb_addr = '0; wb_line = '0;
    mem_wr_req_ready = 1'b0; mem_wr_data_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({wb_ready, wb_done, mem_wr_req_valid, mem_wr_data_valid, mem_wr_data_last} !== 5'b10000)
      $display("FAIL reset_ctrl: got %b expected 10000",
               {wb_ready, wb_done, mem_wr_req_valid, mem_wr_data_valid, mem_wr_data_last});
    else passed++;
    checks++;
    if (mem_wr_addr !== '0) $display("FAIL reset_addr: got %h expected 0", mem_wr_addr);
    else passed++;
    checks++;
    if (mem_wr_data !== '0) $display("FAIL reset_data: got %h expected 0", mem_wr_data);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [DW*LW-1:0] l;
    logic [DW-1:0]    e;
    l = make_line(32'h1000_0000);
    push_line(l);
    mem_wr_req_ready = 1'b1; mem_wr_data_ready = 1'b1;
    wb_valid = 1'b1; wb_addr = 32'h0000_1234; wb_line = l;
    tick();
    // cycle 1: request; inputs scrambled to prove they were captured
    wb_valid = 1'b0; wb_addr = 32'hFFFF_FFFF; wb_line = ~l;
    checks++;
    if (mem_wr_req_valid !== 1'b1 || mem_wr_addr !== 32'h0000_1220)
      $display("FAIL basic_req: got valid=%b addr=%h expected valid=1 addr=00001220",
               mem_wr_req_valid, mem_wr_addr);
    else passed++;
    checks++;
    if (mem_wr_len !== 8'd7) $display("FAIL basic_len: got %0d expected 7", mem_wr_len);
    else passed++;
    checks++;
    if (mem_wr_data_valid !== 1'b0) $display("FAIL basic_req_overlap: got dv=%b expected 0", mem_wr_data_valid);
    else passed++;
    tick();
    // cycles 2..9: one beat per cycle
    for (int i = 0; i < LW; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (mem_wr_data_valid !== 1'b1 || mem_wr_data !== e || mem_wr_req_valid !== 1'b0)
        $display("FAIL basic_beat%0d: got dv=%b data=%h rv=%b expected dv=1 data=%h rv=0",
                 i, mem_wr_data_valid, mem_wr_data, mem_wr_req_valid, e);
      else passed++;
      checks++;
      if (mem_wr_data_last !== (i == LW - 1))
        $display("FAIL basic_last%0d: got %b expected %b", i, mem_wr_data_last, (i == LW - 1));
      else passed++;
      tick();
    end
    // cycle 10: done pulse
    checks++;
    if (wb_done !== 1'b1 || wb_ready !== 1'b0 || mem_wr_data_valid !== 1'b0)
      $display("FAIL basic_done: got done=%b rdy=%b dv=%b expected 1 0 0",
               wb_done, wb_ready, mem_wr_data_valid);
    else passed++;
    tick();
    // cycle 11: idle again
    checks++;
    if (wb_done !== 1'b0 || wb_ready !== 1'b1)
      $display("FAIL basic_idle: got done=%b rdy=%b expected 0 1", wb_done, wb_ready);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [DW*LW-1:0] l;
    logic [DW-1:0]    e, prev_d;
    logic             prev_l;
    bit               stalled;
    int               nb, nd, k, post;
    l = make_line(32'hA5A5_0000);
    push_line(l);
    mem_wr_req_ready = 1'b0; mem_wr_data_ready = 1'b0;
    wb_valid = 1'b1; wb_addr = 32'h8000_00FF; wb_line = l;
    tick();
    wb_valid = 1'b0; wb_line = '0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (mem_wr_req_valid !== 1'b1 || mem_wr_addr !== 32'h8000_00E0 || mem_wr_data_valid !== 1'b0)
        $display("FAIL bp_req_hold%0d: got rv=%b addr=%h dv=%b expected 1 800000e0 0",
                 c, mem_wr_req_valid, mem_wr_addr, mem_wr_data_valid);
      else passed++;
      tick();
    end
    mem_wr_req_ready = 1'b1;
    checks++;
    if (mem_wr_req_valid !== 1'b1) $display("FAIL bp_req_final: got %b expected 1", mem_wr_req_valid);
    else passed++;
    tick();
    mem_wr_req_ready = 1'b0;
    nb = 0; nd = 0; k = 0; post = 0; stalled = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int c = 0; c < 80; c++) begin
      mem_wr_data_ready = (k % 3 == 0);
      k++;
      if (wb_done === 1'b1) nd++;
      if (mem_wr_data_valid === 1'b1) begin
        if (stalled) begin
          checks++;
          if (mem_wr_data !== prev_d || mem_wr_data_last !== prev_l)
            $display("FAIL bp_stall_stable: got %h/%b expected %h/%b",
                     mem_wr_data, mem_wr_data_last, prev_d, prev_l);
          else passed++;
        end
        if (mem_wr_data_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL bp_extra_beat: got %h expected none", mem_wr_data);
          end else begin
            e = exp_q.pop_front();
            if (mem_wr_data !== e || mem_wr_data_last !== (nb == LW - 1))
              $display("FAIL bp_beat%0d: got %h/%b expected %h/%b",
                       nb, mem_wr_data, mem_wr_data_last, e, (nb == LW - 1));
            else passed++;
          end
          nb++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
        prev_d = mem_wr_data;
        prev_l = mem_wr_data_last;
      end
      tick();
      if (nd > 0) post++;
      if (post > 3) break;
    end
    mem_wr_data_ready = 1'b0;
    checks++;
    if (nb !== LW || exp_q.size() !== 0)
      $display("FAIL bp_beat_count: got %0d beats, %0d left expected %0d, 0", nb, exp_q.size(), LW);
    else passed++;
    checks++;
    if (nd !== 1) $display("FAIL bp_done_count: got %0d expected 1", nd);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_busy_ignore();
    logic [DW*LW-1:0] la, lb;
    logic [DW-1:0]    e;
    int               nd, nb, acc;
    bit               prev_done, early_rdy;
    la = make_line(32'h2000_0000);
    lb = make_line(32'h3000_0000);
    push_line(la);
    push_line(lb);
    mem_wr_req_ready = 1'b1; mem_wr_data_ready = 1'b1;
    wb_valid = 1'b1; wb_addr = 32'h0000_4000; wb_line = la;
    tick();
    wb_addr = 32'h0000_5010; wb_line = lb;
    nd = 0; nb = 0; acc = 0; prev_done = 1'b0; early_rdy = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (mem_wr_data_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL busy_extra_beat: got %h expected none", mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          if (mem_wr_data !== e) $display("FAIL busy_beat%0d: got %h expected %h", nb, mem_wr_data, e);
          else passed++;
        end
        nb++;
      end
      if (wb_ready === 1'b1 && wb_valid && acc == 0) begin
        acc++;
        checks++;
        if (prev_done !== 1'b1 || nd !== 1)
          $display("FAIL busy_accept_time: got prev_done=%b dones=%0d expected 1 1", prev_done, nd);
        else passed++;
        tick();
        wb_valid = 1'b0;
        checks++;
        if (mem_wr_req_valid !== 1'b1 || mem_wr_addr !== 32'h0000_5000)
          $display("FAIL busy_req2: got rv=%b addr=%h expected 1 00005000", mem_wr_req_valid, mem_wr_addr);
        else passed++;
        prev_done = 1'b0;
        continue;
      end
      if (wb_ready === 1'b1 && nd == 0) early_rdy = 1'b1;
      prev_done = wb_done;
      if (wb_done === 1'b1) nd++;
      if (nd == 2) break;
      tick();
    end
    wb_valid = 1'b0;
    checks++;
    if (early_rdy !== 1'b0) $display("FAIL busy_ready_while_busy: got 1 expected 0");
    else passed++;
    checks++;
    if (nd !== 2 || nb !== 2 * LW || exp_q.size() !== 0)
      $display("FAIL busy_totals: got dones=%0d beats=%0d expected 2 %0d", nd, nb, 2 * LW);
    else passed++;
    exp_q.delete();
    tick(); tick();
  endtask

  // Accepts beats with all readies high until wb_done (bounded), returning
  // observed beats and last flags for the caller to compare.
  task automatic collect(output logic [DW-1:0] d[$], output logic lst[$], output int nd);
    d.delete(); lst.delete(); nd = 0;
    mem_wr_req_ready = 1'b1; mem_wr_data_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (mem_wr_data_valid === 1'b1) begin
        d.push_back(mem_wr_data);
        lst.push_back(mem_wr_data_last);
      end
      if (wb_done === 1'b1) begin
        nd++;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [DW*LW-1:0] l;
    logic [DW-1:0]    d[$];
    logic             lst[$];
    logic [DW-1:0]    e;
    int               nb, nd;
    l = make_line(32'h4000_0000);
    push_line(l);
    mem_wr_req_ready = 1'b1; mem_wr_data_ready = 1'b1;
    wb_valid = 1'b1; wb_addr = 32'h0001_0040; wb_line = l;
    tick();
    wb_valid = 1'b0;
    nb = 0;
    for (int c = 0; c < 20 && nb < 4; c++) begin
      if (mem_wr_data_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (mem_wr_data !== e) $display("FAIL rstmid_beat%0d: got %h expected %h", nb, mem_wr_data, e);
        else passed++;
        nb++;
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({wb_ready, wb_done, mem_wr_req_valid, mem_wr_data_valid, mem_wr_data_last} !== 5'b10000)
      $display("FAIL rstmid_state: got %b expected 10000",
               {wb_ready, wb_done, mem_wr_req_valid, mem_wr_data_valid, mem_wr_data_last});
    else passed++;
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      if (wb_done === 1'b1 || mem_wr_data_valid === 1'b1) nd++;
      tick();
    end
    checks++;
    if (nd !== 0) $display("FAIL rstmid_no_done: got %0d active cycles expected 0", nd);
    else passed++;
    exp_q.delete();
    l = make_line(32'h5000_0000);
    push_line(l);
    wb_valid = 1'b1; wb_addr = 32'h0002_0000; wb_line = l;
    tick();
    wb_valid = 1'b0;
    collect(d, lst, nd);
    checks++;
    if (d.size() !== LW || nd !== 1)
      $display("FAIL rstmid_new_count: got %0d beats %0d dones expected %0d 1", d.size(), nd, LW);
    else passed++;
    for (int i = 0; i < d.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (d[i] !== e || lst[i] !== (i == LW - 1))
        $display("FAIL rstmid_new_beat%0d: got %h/%b expected %h/%b", i, d[i], lst[i], e, (i == LW - 1));
      else passed++;
    end
    exp_q.delete();
  endtask

  task automatic test_spurious_ready();
    logic [DW*LW-1:0] l;
    logic [DW-1:0]    d[$];
    logic             lst[$];
    logic [DW-1:0]    e;
    int               nd;
    l = make_line(32'h6000_0000);
    mem_wr_req_ready = 1'b0; mem_wr_data_ready = 1'b1; wb_valid = 1'b0;
    tick(); tick(); tick();
    push_line(l);
    wb_valid = 1'b1; wb_addr = 32'h0003_001C; wb_line = l;
    tick();
    wb_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (mem_wr_data_valid !== 1'b0 || mem_wr_req_valid !== 1'b1)
        $display("FAIL spur_req%0d: got dv=%b rv=%b expected 0 1", c, mem_wr_data_valid, mem_wr_req_valid);
      else passed++;
      tick();
    end
    collect(d, lst, nd);
    checks++;
    if (d.size() !== LW || nd !== 1)
      $display("FAIL spur_count: got %0d beats %0d dones expected %0d 1", d.size(), nd, LW);
    else passed++;
    for (int i = 0; i < d.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (d[i] !== e) $display("FAIL spur_beat%0d: got %h expected %h", i, d[i], e);
      else passed++;
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    tick();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_spurious_ready();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cache_wb_serializer.md
Name: cache_wb_serializer

Overview:
- Write-back engine for the D-cache. It accepts one evicted dirty line, read whole from one way's data array.
- It streams that line to memory as a single burst: one address-request handshake followed by LINE_WORDS data beats.
- It is the inverse of the refill path, which shifts incoming words into the top of the line. This block shifts words out of the bottom, word 0 (lowest offset) first.
- It sits between the cache controller's EVICT state and the memory write channel.

Parameters:
DATA_WIDTH, 32, width of one memory beat / cache word
LINE_WORDS, 8, words per cache line (line width = DATA_WIDTH*LINE_WORDS = 256)
ADDR_WIDTH, 32, byte address width
OFFSET_WIDTH, 5, byte-offset bits within a line (log2 of line bytes)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
wb_valid  input  1  controller requests a write-back
wb_ready  output  1  engine idle, able to accept a line
wb_addr  input  ADDR_WIDTH  line address; low OFFSET_WIDTH bits ignored
wb_line  input  DATA_WIDTH*LINE_WORDS  line data; word i = bits [DATA_WIDTH*i +: DATA_WIDTH]
wb_done  output  1  one-cycle pulse after the last beat is accepted
mem_wr_req_valid  output  1  burst write request valid
mem_wr_req_ready  input  1  memory accepts the request
mem_wr_addr  output  ADDR_WIDTH  burst base address, line aligned
mem_wr_len  output  8  beats minus one, constant LINE_WORDS-1
mem_wr_data_valid  output  1  data beat valid
mem_wr_data_ready  input  1  memory accepts the beat
mem_wr_data  output  DATA_WIDTH  current beat
mem_wr_data_last  output  1  final beat of the burst

Behaviour:
- FSM states: IDLE, REQ, DATA, DONE. All outputs are decoded from state or registers; there are no combinational paths from inputs to outputs.
- Reset: state=IDLE, beat counter=0, shift register=0, address register=0.
- Output values at reset: wb_ready=1, wb_done=0, mem_wr_req_valid=0, mem_wr_data_valid=0, mem_wr_data_last=0, mem_wr_addr=0, mem_wr_data=0.
- IDLE:
  - wb_ready=1.
  - When wb_valid&&wb_ready: capture wb_line into the shift register.
  - Capture {wb_addr[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'b0} into the address register.
  - Clear the counter and go to REQ.
  - Input is sampled only on this handshake; wb_line and wb_addr may change afterwards.
- REQ:
  - mem_wr_req_valid=1 and mem_wr_addr=address register.
  - On mem_wr_req_ready, go to DATA.
  - Minimum gap is 1 cycle between the wb handshake and req_valid.
- DATA:
  - mem_wr_data_valid=1 and mem_wr_data=shift register [DATA_WIDTH-1:0].
  - mem_wr_data_last=1 when counter==LINE_WORDS-1.
  - On mem_wr_data_ready: shift the register right by DATA_WIDTH (zero fill) and increment the counter.
  - If that beat was last, go to DONE.
  - Memory may hold ready low for any number of cycles; data, last and valid stay stable while stalled.
  - Full-rate throughput is 1 beat/cycle.
- DONE:
  - wb_done=1 for exactly one cycle, then go to IDLE.
  - wb_ready=0 in DONE, so a new line is accepted no earlier than the cycle after wb_done.
- Handshake rules:
  - valid, once asserted, never drops before its ready.
  - The request and data channels never overlap: data_valid=0 while in REQ.
  - A mem_wr_data_ready asserted during REQ or IDLE is ignored.
- Counter: log2(LINE_WORDS) bits. It reaches LINE_WORDS-1 and does not wrap within a burst; it is reset on each new accept.
- Total latency with memory always ready: wb handshake at cycle 0, req at cycle 1, beats at cycles 2..9, wb_done at cycle 10, wb_ready at cycle 11.
- rst in any state: IDLE is reached on the next edge. Any in-flight burst is abandoned with no wb_done, and all valids are low in the following cycle.
- wb_valid while busy: ignored (wb_ready=0). The controller must hold wb_valid until the handshake.

Test Plan:
- Reset: assert rst 2 cycles -> wb_ready=1, all valids=0, wb_done=0, mem_wr_addr=0.
- Basic burst: line words i=0x1000_0000+i, wb_addr=0x0000_1234, all readies high -> req at cycle 1 with addr 0x0000_1220 and len=7; beats 0x10000000..0x10000007 in order at cycles 2..9; last only on 0x10000007; wb_done at cycle 10.
- Backpressure: req_ready low 3 cycles, then data_ready toggling 1,0,0,1,... -> req_valid/addr held stable; each beat held unchanged while stalled; exactly 8 accepted beats, no duplicates or skips; single wb_done.
- Busy ignore: wb_valid held high with a second line during the burst -> second line accepted only the cycle after wb_done; its first beat is its own word 0.
- Reset mid-burst: rst asserted after beat 3 accepted -> next cycle IDLE, valids=0, no wb_done. A new line then bursts from word 0.
- Spurious ready: data_ready=1 during IDLE/REQ -> counter unaffected; first DATA beat is word 0.
